// File: rtl/dsp_seq_pkg.sv
// Shared encodings and constants for the DSP48A1 dot-product sequencer.
package dsp_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [7:0]  OPMODE_FIRST = 8'h01;  // X=M, Z=0: start a new sum
  localparam logic [7:0]  OPMODE_ACC   = 8'h09;  // X=M, Z=P: accumulate
  localparam int unsigned PIPE_LAT     = 3;      // A1/B1 -> M -> P
  localparam int unsigned OPND_W       = 18;
  localparam int unsigned P_W          = 48;

endpackage

// File: rtl/valid_pipe.sv
// Shift pipeline tracking which slice stages hold real samples and which one is the first pair.
module valid_pipe #(
  parameter int unsigned DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_first,
  output logic [DEPTH-1:0] valid_o,
  output logic [DEPTH-1:0] first_o
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] first_q, first_d;

  // Shift one stage per cycle; a bubble enters as an invalid slot.
  always_comb begin
    valid_d = {valid_q[DEPTH-2:0], in_valid};
    first_d = {first_q[DEPTH-2:0], in_valid & in_first};
  end

  // Stage registers, cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      first_q <= '0;
    end else begin
      valid_q <= valid_d;
      first_q <= first_d;
    end
  end

  assign valid_o = valid_q;
  assign first_o = first_q;

endmodule

// File: rtl/dsp_mac_seq.sv
// Sequences an external DSP48A1 slice through an N-pair unsigned dot product.
module dsp_mac_seq #(
  parameter int unsigned LEN_W    = 8,
  parameter int unsigned PIPE_LAT = dsp_seq_pkg::PIPE_LAT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [LEN_W-1:0] LEN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [17:0]      A_IN,
  input  logic [17:0]      B_IN,
  output logic [17:0]      DSP_A,
  output logic [17:0]      DSP_B,
  output logic [7:0]       DSP_OPMODE,
  output logic             DSP_CEA,
  output logic             DSP_CEB,
  output logic             DSP_CEM,
  output logic             DSP_CEP,
  output logic             DSP_CEOPMODE,
  output logic             DSP_RSTP,
  input  logic [47:0]      DSP_P,
  output logic [47:0]      RESULT,
  output logic             RESULT_VALID,
  input  logic             RESULT_READY,
  output logic             BUSY
);
  import dsp_seq_pkg::*;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic             first_q, first_d;
  logic [P_W-1:0]   result_q, result_d;
  logic [7:0]       opmode_q, opmode_d;
  logic             in_ready_q, in_ready_d;
  logic             ce_q, ce_d;
  logic             busy_q, busy_d;
  logic             rvalid_q, rvalid_d;
  logic             rstp_q;
  logic             xfer;
  logic             active;

  logic [PIPE_LAT-1:0] vp_valid;
  logic [PIPE_LAT-1:0] vp_first;
  logic                first_pipe_unused;

  valid_pipe #(.DEPTH(PIPE_LAT)) u_valid_pipe (
    .clk      (CLK),
    .rst      (RST),
    .in_valid (xfer),
    .in_first (first_q),
    .valid_o  (vp_valid),
    .first_o  (vp_first)
  );

  assign first_pipe_unused = ^vp_first;

  // Next-state, counters, OPMODE selection and result capture.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    first_d  = first_q;
    result_d = result_q;
    opmode_d = opmode_q;
    xfer     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          if (LEN == LEN_W'(0)) begin
            state_d  = ST_DONE;
            result_d = '0;
          end else begin
            state_d = ST_RUN;
            count_d = LEN;
            first_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (IN_VALID && in_ready_q) begin
          xfer     = 1'b1;
          count_d  = count_q - LEN_W'(1);
          first_d  = 1'b0;
          opmode_d = first_q ? OPMODE_FIRST : OPMODE_ACC;
          if (count_q == LEN_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Last sample has landed in P and nothing else is in flight.
        if (vp_valid[PIPE_LAT-1] && !(|vp_valid[PIPE_LAT-2:0])) begin
          state_d  = ST_DONE;
          result_d = DSP_P;
        end
      end
      ST_DONE: begin
        if (RESULT_READY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    active     = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    in_ready_d = (state_d == ST_RUN);
    ce_d       = active;
    busy_d     = (state_d != ST_IDLE);
    rvalid_d   = (state_d == ST_DONE);
    if (!active) opmode_d = '0;
  end

  // Control and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      first_q    <= 1'b0;
      result_q   <= '0;
      opmode_q   <= '0;
      in_ready_q <= 1'b0;
      ce_q       <= 1'b0;
      busy_q     <= 1'b0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      first_q    <= first_d;
      result_q   <= result_d;
      opmode_q   <= opmode_d;
      in_ready_q <= in_ready_d;
      ce_q       <= ce_d;
      busy_q     <= busy_d;
      rvalid_q   <= rvalid_d;
    end
  end

  // Slice P reset follows our reset by one cycle.
  always_ff @(posedge CLK) begin
    rstp_q <= RST;
  end

  assign DSP_A        = A_IN;
  assign DSP_B        = B_IN;
  assign DSP_OPMODE   = opmode_q;
  assign DSP_CEA      = ce_q;
  assign DSP_CEB      = ce_q;
  assign DSP_CEM      = ce_q;
  assign DSP_CEOPMODE = ce_q;
  assign DSP_CEP      = vp_valid[PIPE_LAT-2];
  assign DSP_RSTP     = rstp_q;
  assign IN_READY     = in_ready_q;
  assign RESULT       = result_q;
  assign RESULT_VALID = rvalid_q;
  assign BUSY         = busy_q;

endmodule

// File: tb/tb_dsp_mac_seq.sv
// Self-checking bench for dsp_mac_seq with a behavioural DSP48A1 slice attached.
module tb_dsp_mac_seq;

  localparam int unsigned LEN_W = 8;
  localparam int unsigned LAT   = 3;

  logic             CLK;
  logic             RST;
  logic             START;
  logic [LEN_W-1:0] LEN;
  logic             IN_VALID;
  logic             IN_READY;
  logic [17:0]      A_IN, B_IN;
  logic [17:0]      DSP_A, DSP_B;
  logic [7:0]       DSP_OPMODE;
  logic             DSP_CEA, DSP_CEB, DSP_CEM, DSP_CEP, DSP_CEOPMODE, DSP_RSTP;
  logic [47:0]      DSP_P;
  logic [47:0]      RESULT;
  logic             RESULT_VALID;
  logic             RESULT_READY;
  logic             BUSY;

  int checks   = 0;
  int failures = 0;

  logic [17:0] op_a[$];
  logic [17:0] op_b[$];
  int          gaps[$];

  dsp_mac_seq #(.LEN_W(LEN_W), .PIPE_LAT(LAT)) dut (
    .CLK(CLK), .RST(RST), .START(START), .LEN(LEN),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .A_IN(A_IN), .B_IN(B_IN),
    .DSP_A(DSP_A), .DSP_B(DSP_B), .DSP_OPMODE(DSP_OPMODE),
    .DSP_CEA(DSP_CEA), .DSP_CEB(DSP_CEB), .DSP_CEM(DSP_CEM), .DSP_CEP(DSP_CEP),
    .DSP_CEOPMODE(DSP_CEOPMODE), .DSP_RSTP(DSP_RSTP), .DSP_P(DSP_P),
    .RESULT(RESULT), .RESULT_VALID(RESULT_VALID), .RESULT_READY(RESULT_READY),
    .BUSY(BUSY)
  );

  // DSP48A1 model: A1REG=B1REG=MREG=PREG=OPMODEREG=1, X/Z multiplexers only.
  logic [17:0] s_a1 = '0;
  logic [17:0] s_b1 = '0;
  logic [35:0] s_m  = '0;
  logic [7:0]  s_op = '0;
  logic [47:0] s_p  = '0;
  logic [47:0] s_x, s_z;
  assign s_x   = (s_op[1:0] == 2'b01) ? 48'(s_m) : 48'd0;
  assign s_z   = (s_op[3:2] == 2'b10) ? s_p : 48'd0;
  assign DSP_P = s_p;

  always @(posedge CLK) begin
    if (DSP_CEA) s_a1 <= DSP_A;
    if (DSP_CEB) s_b1 <= DSP_B;
    if (DSP_CEM) s_m <= 36'(s_a1) * 36'(s_b1);
    if (DSP_CEOPMODE) s_op <= DSP_OPMODE;
    if (DSP_RSTP) s_p <= '0;
    else if (DSP_CEP) s_p <= s_z + s_x;
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Dot product of the first len queued pairs, modulo 2^48.
  function automatic logic [47:0] model_dot(input int unsigned len);
    logic [47:0] acc = '0;
    for (int i = 0; i < int'(len); i++) acc = acc + 48'(op_a[i]) * 48'(op_b[i]);
    return acc;
  endfunction

  function automatic int model_lat(input int unsigned len);
    int g = 0;
    if (len == 0) return 1;
    for (int i = 0; i < int'(len); i++) g += gaps[i];
    return int'(len) + g + LAT + 1;
  endfunction

  // Drive one operation from START until RESULT_VALID; leaves RESULT_READY low.
  task automatic run_op(input int unsigned len, output int lat, output logic [47:0] res,
                        output int cep_cnt, output bit ce_any, output bit tmo);
    int idx = 0;
    int gap;
    bit xfer;
    lat = 0; cep_cnt = 0; ce_any = 1'b0; tmo = 1'b0;
    gap = (len > 0) ? gaps[0] : 0;
    LEN = LEN_W'(len);
    START = 1'b1;
    IN_VALID = 1'b0;
    step();
    START = 1'b0;
    lat = 1;
    while (!RESULT_VALID) begin
      cep_cnt += int'(DSP_CEP);
      ce_any |= DSP_CEA | DSP_CEB | DSP_CEM | DSP_CEP | DSP_CEOPMODE;
      if (IN_READY && idx < int'(len)) begin
        if (gap > 0) begin
          IN_VALID = 1'b0;
          gap--;
        end else begin
          IN_VALID = 1'b1;
          A_IN = op_a[idx];
          B_IN = op_b[idx];
        end
      end else begin
        IN_VALID = 1'b0;
      end
      xfer = IN_VALID && IN_READY;
      step();
      lat++;
      if (xfer) begin
        idx++;
        if (idx < int'(len)) gap = gaps[idx];
      end
      if (lat > 300) begin
        tmo = 1'b1;
        break;
      end
    end
    ce_any |= DSP_CEA | DSP_CEB | DSP_CEM | DSP_CEP | DSP_CEOPMODE;
    IN_VALID = 1'b0;
    res = RESULT;
  endtask

  task automatic ack();
    RESULT_READY = 1'b1;
    step();
    RESULT_READY = 1'b0;
  endtask

  task automatic load_ops(input logic [17:0] a[$], input logic [17:0] b[$], input int g[$]);
    op_a = a; op_b = b; gaps = g;
  endtask

  task automatic test_reset();
    RST = 1'b1; START = 1'b1; LEN = 8'd3; IN_VALID = 1'b1; RESULT_READY = 1'b0;
    A_IN = 18'd5; B_IN = 18'd7;
    step(); step();
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    checks++; if (RESULT_VALID !== 1'b0) begin failures++; $display("FAIL reset_rvalid: got %b want 0", RESULT_VALID); end
    checks++; if (IN_READY !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b want 0", IN_READY); end
    checks++; if (DSP_OPMODE !== 8'h00) begin failures++; $display("FAIL reset_opmode: got %h want 00", DSP_OPMODE); end
    checks++;
    if ({DSP_CEA, DSP_CEB, DSP_CEM, DSP_CEP, DSP_CEOPMODE} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ce: got %b want 00000", {DSP_CEA, DSP_CEB, DSP_CEM, DSP_CEP, DSP_CEOPMODE});
    end
    checks++; if (RESULT !== 48'd0) begin failures++; $display("FAIL reset_result: got %h want 0", RESULT); end
    checks++; if (DSP_RSTP !== 1'b1) begin failures++; $display("FAIL reset_rstp_high: got %b want 1", DSP_RSTP); end
    RST = 1'b0; START = 1'b0; IN_VALID = 1'b0;
    step();
    checks++; if (DSP_RSTP !== 1'b0) begin failures++; $display("FAIL reset_rstp_low: got %b want 0", DSP_RSTP); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_start_ignored: busy %b want 0", BUSY); end
  endtask

  task automatic test_basic();
    int lat, cep; bit ce, tmo; logic [47:0] res;
    load_ops('{18'd1, 18'd3, 18'd5, 18'd7}, '{18'd2, 18'd4, 18'd6, 18'd8}, '{0, 0, 0, 0});
    run_op(4, lat, res, cep, ce, tmo);
    checks++; if (tmo) begin failures++; $display("FAIL basic_timeout: no RESULT_VALID"); end
    checks++; if (res !== 48'd100) begin failures++; $display("FAIL basic_result: got %0d want 100", res); end
    checks++; if (lat != 8) begin failures++; $display("FAIL basic_latency: got %0d want 8", lat); end
    checks++; if (cep != 4) begin failures++; $display("FAIL basic_cep: got %0d want 4", cep); end
    ack();
    checks++; if (BUSY !== 1'b0 || RESULT_VALID !== 1'b0) begin failures++; $display("FAIL basic_idle: busy %b rvalid %b want 0 0", BUSY, RESULT_VALID); end
  endtask

  task automatic test_bubbles();
    int lat, cep; bit ce, tmo; logic [47:0] res;
    load_ops('{18'd2, 18'd4, 18'd6}, '{18'd3, 18'd5, 18'd7}, '{0, 2, 0});
    run_op(3, lat, res, cep, ce, tmo);
    checks++; if (res !== 48'd68 || tmo) begin failures++; $display("FAIL bubble_result: got %0d want 68", res); end
    checks++; if (cep != 3) begin failures++; $display("FAIL bubble_cep: got %0d want 3", cep); end
    checks++; if (lat != 9) begin failures++; $display("FAIL bubble_latency: got %0d want 9", lat); end
    ack();
  endtask

  task automatic test_len0();
    int lat, cep; bit ce, tmo; logic [47:0] res;
    load_ops('{}, '{}, '{});
    run_op(0, lat, res, cep, ce, tmo);
    checks++; if (lat != 1 || tmo) begin failures++; $display("FAIL len0_latency: got %0d want 1", lat); end
    checks++; if (res !== 48'd0) begin failures++; $display("FAIL len0_result: got %h want 0", res); end
    checks++; if (ce) begin failures++; $display("FAIL len0_ce: got CE activity want none"); end
    ack();
  endtask

  task automatic test_back_to_back();
    int lat, cep; bit ce, tmo; logic [47:0] res;
    load_ops('{18'h3FFFF}, '{18'h3FFFF}, '{0});
    run_op(1, lat, res, cep, ce, tmo);
    checks++; if (res !== 48'hF_FFF8_0001 || tmo) begin failures++; $display("FAIL b2b_first: got %h want FFFF80001", res); end
    ack();
    load_ops('{18'd1}, '{18'd1}, '{0});
    run_op(1, lat, res, cep, ce, tmo);
    checks++; if (res !== 48'd1 || tmo) begin failures++; $display("FAIL b2b_second: got %h want 1", res); end
    ack();
  endtask

  task automatic test_reset_mid_run();
    int lat, cep, rv_seen; bit ce, tmo; logic [47:0] res;
    LEN = 8'd5; START = 1'b1;
    step();
    START = 1'b0;
    IN_VALID = 1'b1; A_IN = 18'd11; B_IN = 18'd12;
    step();
    A_IN = 18'd13; B_IN = 18'd14;
    step();
    IN_VALID = 1'b0; RST = 1'b1;
    step();
    RST = 1'b0;
    checks++; if (BUSY !== 1'b0 || IN_READY !== 1'b0) begin failures++; $display("FAIL midrst_idle: busy %b in_ready %b want 0 0", BUSY, IN_READY); end
    checks++; if (DSP_RSTP !== 1'b1) begin failures++; $display("FAIL midrst_rstp: got %b want 1", DSP_RSTP); end
    rv_seen = 0;
    for (int i = 0; i < 10; i++) begin
      rv_seen += int'(RESULT_VALID);
      step();
    end
    checks++; if (rv_seen != 0) begin failures++; $display("FAIL midrst_no_result: got %0d valid cycles want 0", rv_seen); end
    load_ops('{18'd9}, '{18'd9}, '{0});
    run_op(1, lat, res, cep, ce, tmo);
    checks++; if (res !== 48'd81 || tmo) begin failures++; $display("FAIL midrst_restart: got %0d want 81", res); end
    checks++; if (lat != 5) begin failures++; $display("FAIL midrst_latency: got %0d want 5", lat); end
    ack();
  endtask

  task automatic test_hold();
    int lat, cep, bad; bit ce, tmo; logic [47:0] res;
    load_ops('{18'd10, 18'd20}, '{18'd3, 18'd4}, '{0, 0});
    run_op(2, lat, res, cep, ce, tmo);
    checks++; if (res !== 48'd110 || tmo) begin failures++; $display("FAIL hold_result: got %0d want 110", res); end
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      START = k[0]; LEN = 8'd2; IN_VALID = 1'b1;
      step();
      checks++;
      if (RESULT !== 48'd110 || RESULT_VALID !== 1'b1 || BUSY !== 1'b1) begin
        failures++;
        $display("FAIL hold_cycle%0d: result %0d rvalid %b busy %b want 110 1 1", k, RESULT, RESULT_VALID, BUSY);
      end
    end
    IN_VALID = 1'b0;
    START = 1'b1;
    ack();
    START = 1'b0;
    checks++; if (BUSY !== 1'b0 || RESULT_VALID !== 1'b0) begin failures++; $display("FAIL hold_ack: busy %b rvalid %b want 0 0", BUSY, RESULT_VALID); end
    step();
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL hold_start_on_ack: busy %b want 0", BUSY); end
    if (bad != 0) failures++;
  endtask

  task automatic test_random();
    int lat, cep, n; bit ce, tmo; logic [47:0] res, exp_res;
    logic [17:0] a[$]; logic [17:0] b[$]; int g[$];
    for (int t = 0; t < 8; t++) begin
      n = int'($urandom_range(1, 12));
      a = {}; b = {}; g = {};
      for (int i = 0; i < n; i++) begin
        a.push_back(($urandom_range(0, 3) == 0) ? 18'h3FFFF : 18'($urandom));
        b.push_back(($urandom_range(0, 3) == 0) ? 18'h3FFFF : 18'($urandom));
        g.push_back(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 2)));
      end
      load_ops(a, b, g);
      exp_res = model_dot(n);
      run_op(n, lat, res, cep, ce, tmo);
      checks++; if (res !== exp_res || tmo) begin failures++; $display("FAIL rand%0d_result: got %h want %h", t, res, exp_res); end
      checks++; if (lat != model_lat(n)) begin failures++; $display("FAIL rand%0d_latency: got %0d want %0d", t, lat, model_lat(n)); end
      checks++; if (cep != n) begin failures++; $display("FAIL rand%0d_cep: got %0d want %0d", t, cep, n); end
      for (int w = 0; w < int'($urandom_range(0, 3)); w++) step();
      ack();
    end
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; LEN = '0; IN_VALID = 1'b0; RESULT_READY = 1'b0;
    A_IN = '0; B_IN = '0;
    test_reset();
    test_basic();
    test_bubbles();
    test_len0();
    test_back_to_back();
    test_reset_mid_run();
    test_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dsp_mac_seq.md
DSP_MAC_SEQ -- requirements
Module: dsp_mac_seq

Interface
REQ-001 Parameter LEN_W, default 8, width of the sample-count port.
REQ-002 Parameter PIPE_LAT, default 3, operand-to-P latency of the attached slice: A1REG=1, B1REG=1, MREG=1, PREG=1, OPMODEREG=1, A0REG=B0REG=0, B_INPUT="DIRECT".
REQ-003 CLK  in  1  sole clock; all logic updates on its rising edge.
REQ-004 RST  in  1  reset, synchronous and active-high.
REQ-005 START  in  1  one-cycle request to begin a dot product; sampled only in IDLE.
REQ-006 LEN  in  LEN_W  number of sample pairs; captured when START is accepted.
REQ-007 IN_VALID / IN_READY  in / out  1 / 1  operand handshake; a pair transfers on a cycle where both are high.
REQ-008 A_IN, B_IN  in  18 each  operand pair.
REQ-009 DSP_A, DSP_B  out  18 each  operands to the slice.
REQ-010 DSP_OPMODE  out  8  slice OPMODE.
REQ-011 DSP_CEA, DSP_CEB, DSP_CEM, DSP_CEP, DSP_CEOPMODE  out  1 each  slice clock enables.
REQ-012 DSP_RSTP  out  1  slice P-register reset.
REQ-013 DSP_P  in  48  slice P output.
REQ-014 RESULT  out  48  accumulated dot product.
REQ-015 RESULT_VALID / RESULT_READY  out / in  1 / 1  result handshake.
REQ-016 BUSY  out  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-018 IDLE -> RUN on START with LEN!=0; IDLE -> DONE on START with LEN==0, with RESULT=0 and no slice activity.
REQ-019 RUN: IN_READY=1; the remaining count decrements per transfer; after the LEN-th transfer -> DRAIN.
REQ-020 DRAIN: IN_READY=0; lasts until the valid pipeline is empty (PIPE_LAT cycles after the last transfer) -> DONE.
REQ-021 DONE: RESULT_VALID=1, RESULT stable; -> IDLE on the RESULT_READY cycle.
REQ-022 DSP_A/DSP_B = A_IN/B_IN combinationally; DSP_CEA=DSP_CEB=DSP_CEM=DSP_CEOPMODE=1 in RUN and DRAIN, else 0.
REQ-023 Each transfer enters a 3-stage valid/first shift pipeline; a bubble (IN_VALID=0 in RUN) enters as invalid.
REQ-024 DSP_OPMODE is driven one cycle after the operand transfer: 0x01 (X=M, Z=0) for the first pair and 0x09 (X=M, Z=P) for later pairs; bits 7:4 are always 0 (add, no pre-adder, carry-in 0).
REQ-025 DSP_CEP = stage-2 valid, so P updates only for real samples and holds across bubbles.
REQ-026 RESULT is captured from DSP_P on the first cycle of DONE and held until the handshake completes.
REQ-027 Arithmetic: products are 36-bit unsigned, zero-extended into a 48-bit accumulation that wraps modulo 2^48 with no overflow flag.
REQ-028 Throughput: one pair per cycle; LEN pairs with no bubbles reach RESULT_VALID in LEN+PIPE_LAT+1 cycles after START.
REQ-029 START is ignored outside IDLE; IN_VALID is ignored outside RUN.
REQ-030 When RESULT_VALID and RESULT_READY are both high in the same cycle as START, START is ignored; it is accepted only in IDLE.

Reset
REQ-031 On RST, all outputs go to 0 on the next edge except DSP_RSTP: state=IDLE, count=0, valid pipeline cleared, RESULT=0, RESULT_VALID=0, IN_READY=0, BUSY=0, DSP_OPMODE=0, all CE=0.
REQ-032 DSP_RSTP = RST registered; it is high for each cycle following an RST cycle.
REQ-033 RST mid-RUN or mid-DRAIN abandons the operation with no RESULT_VALID pulse; the next START behaves as if from power-up.

Structure
REQ-034 Package dsp_seq_pkg holds the state encoding, OPMODE_FIRST=8'h01, OPMODE_ACC=8'h09 and PIPE_LAT.
REQ-035 The valid/first shift pipeline is a sub-module named valid_pipe, parameterised by depth.
REQ-036 The slice itself is instantiated outside this block; the bench connects my_DSP48A1 with the REQ-002 parameters.

Verification
REQ-037 LEN=4, pairs (1,2),(3,4),(5,6),(7,8), no bubbles -> RESULT=100, RESULT_VALID exactly 8 cycles after START.
REQ-038 LEN=3, (2,3),(4,5),(6,7), IN_VALID low for 2 cycles between pairs 1 and 2 -> RESULT=68, DSP_CEP high exactly 3 cycles.
REQ-039 LEN=0 -> RESULT_VALID next cycle with RESULT=0, all DSP CEs stay 0.
REQ-040 Two back-to-back ops, first (3FFFF,3FFFF)x1, second (1,1)x1 -> results 0xFFFF80001 then 1, proving the first pair clears accumulation.
REQ-041 RST asserted in RUN after 2 of 5 pairs -> IDLE next cycle, no RESULT_VALID; new LEN=1 (9,9) -> RESULT=81.
REQ-042 RESULT_READY held low for 5 cycles in DONE -> RESULT stable, START pulses ignored, BUSY=1 throughout.
